// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
  localparam int          DEF_REGION_BITS = 12;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } apb_dec_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps an address onto fixed-size completer regions above BASE_ADDR; one-hot PSEL when enabled.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLV     = 5,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                REGION_BITS = DEF_REGION_BITS
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic               en,
  output apb_dec_t           dec,
  output logic [NUM_SLV-1:0] psel
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx_full;

  always_comb begin
    off      = addr - BASE_ADDR;
    idx_full = off >> REGION_BITS;
    // Full-width index compare so addresses far above the last region miss.
    dec.hit  = (addr >= BASE_ADDR) && (idx_full < ADDR_W'(NUM_SLV));
    dec.idx  = idx_full[3:0];
    for (int i = 0; i < NUM_SLV; i++) begin
      psel[i] = en && dec.hit && (dec.idx == 4'(i));
    end
  end

endmodule

// File: rtl/apb_master_n.sv
// APB requester: latches a core load/store, runs SETUP/ACCESS to one of NUM_SLV completers,
// and reports completion with PSLVERR, unmapped-address and wait-timeout errors.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int                NUM_SLV     = 5,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                REGION_BITS = DEF_REGION_BITS,
  parameter int                TIMEOUT     = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err
);

  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;

  apb_dec_t          dec;
  logic              sel_ready, sel_err, done;
  logic [DATA_W-1:0] sel_rdata;

  apb_addr_decoder #(
    .NUM_SLV    (NUM_SLV),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .REGION_BITS(REGION_BITS)
  ) u_dec (
    .addr(paddr_q),
    .en  (state_q != IDLE),
    .dec (dec),
    .psel(PSEL)
  );

  // Completion mux: only the selected completer's response is visible.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dec.hit && dec.idx == 4'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    ready    = 1'b0;
    rdata    = '0;
    err      = 1'b0;
    done     = !dec.hit || sel_ready || (cnt_q == CNT_W'(TIMEOUT - 1));

    unique case (state_q)
      IDLE: if (transfer) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (done) begin
          ready = 1'b1;
          if (dec.hit && sel_ready) begin
            err   = sel_err;
            rdata = pwrite_q ? '0 : sel_rdata;
          end else begin
            err   = 1'b1;
          end
          state_d = transfer ? SETUP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request is taken either from IDLE or in the completing ACCESS cycle.
    if (state_q != SETUP && state_d == SETUP) begin
      paddr_d  = addr;
      pwrite_d = write;
      pwdata_d = wdata;
      pstrb_d  = write ? wstrb : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PENABLE = (state_q == ACCESS);

endmodule
